// File: rtl/wb_write_queue.sv
// Purpose : queues writeback results and drives the register-file write port,
//           forwarding still-pending values to decode.
// Latency : result pushed at edge N appears on regwrite/write_* after edge N+1.
// Backpr. : in_ready drops when DEPTH entries are queued; wb_stall freezes the head.
//
// Ports:
//   clk, reset                       rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_register/in_data   result handshake (writes to $0 are dropped)
//   wb_stall                         register-file write port busy, holds the queue head
//   regwrite/write_register/write_data      registered register-file write port
//   lookup_register_1/2              decode read addresses
//   fwd_hit_1/2, fwd_data_1/2        youngest pending value for each lookup
//   count                            queued entries, not counting the output stage
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_register,
    input  logic [31:0]   in_data,
    input  logic          wb_stall,
    output logic          regwrite,
    output logic [4:0]    write_register,
    output logic [31:0]   write_data,
    input  logic [4:0]    lookup_register_1,
    input  logic [4:0]    lookup_register_2,
    output logic          fwd_hit_1,
    output logic          fwd_hit_2,
    output logic [31:0]   fwd_data_1,
    output logic [31:0]   fwd_data_2,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Queue storage. Address/data carry no reset; the valid bits qualify them.
    logic [4:0]       ent_reg_q [DEPTH];
    logic [31:0]      ent_dat_q [DEPTH];
    logic [DEPTH-1:0] ent_vld_q, ent_vld_d;

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q,  count_d;

    // Output stage feeding the register file.
    logic             regwrite_q,       regwrite_d;
    logic [4:0]       write_register_q, write_register_d;
    logic [31:0]      write_data_q,     write_data_d;

    logic             accept;
    logic             push;
    logic             pop;

    assign in_ready = (count_q != FULL_CNT);
    assign accept   = in_valid && in_ready;
    // A $0 result completes its handshake but never occupies a slot.
    assign push     = accept && (in_register != 5'd0);
    // Pop only looks at the registered count, so an entry pushed into an empty
    // queue waits one edge before it can move to the output stage.
    assign pop      = (count_q != '0) && !wb_stall;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        count_d          = count_q;
        ent_vld_d        = ent_vld_q;
        regwrite_d       = 1'b0;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;

        if (push) begin
            wr_ptr_d            = wr_ptr_q + 1'b1;
            ent_vld_d[wr_ptr_q] = 1'b1;
        end

        // With 0 < count < DEPTH the pointers differ, so this clear never
        // collides with the set above.
        if (pop) begin
            rd_ptr_d            = rd_ptr_q + 1'b1;
            ent_vld_d[rd_ptr_q] = 1'b0;
            regwrite_d          = 1'b1;
            write_register_d    = ent_reg_q[rd_ptr_q];
            write_data_d        = ent_dat_q[rd_ptr_q];
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control and output-stage registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
            ent_vld_q        <= '0;
            regwrite_q       <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
        end else begin
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            count_q          <= count_d;
            ent_vld_q        <= ent_vld_d;
            regwrite_q       <= regwrite_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
        end
    end

    // Entry payload: written on push only.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_reg_q[wr_ptr_q] <= in_register;
            ent_dat_q[wr_ptr_q] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding. The walk starts at the output stage (lowest priority) and
    // then visits entries oldest to youngest, so the last match seen is the
    // youngest pending write. The same-cycle in_data is deliberately ignored.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < 2; k++) begin : g_fwd
        logic [4:0]  lk;
        logic        hit;
        logic [31:0] dat;

        assign lk = (k == 0) ? lookup_register_1 : lookup_register_2;

        always_comb begin
            logic [AW-1:0] idx;
            hit = 1'b0;
            dat = '0;
            idx = '0;
            if (regwrite_q && (write_register_q == lk)) begin
                hit = 1'b1;
                dat = write_data_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + AW'(i);
                if (ent_vld_q[idx] && (ent_reg_q[idx] == lk)) begin
                    hit = 1'b1;
                    dat = ent_dat_q[idx];
                end
            end
            // $0 is hard-wired in the register file; never forward it.
            if (lk == 5'd0) begin
                hit = 1'b0;
                dat = '0;
            end
        end
    end

    assign fwd_hit_1      = g_fwd[0].hit;
    assign fwd_data_1     = g_fwd[0].dat;
    assign fwd_hit_2      = g_fwd[1].hit;
    assign fwd_data_2     = g_fwd[1].dat;

    assign regwrite       = regwrite_q;
    assign write_register = write_register_q;
    assign write_data     = write_data_q;
    assign count          = count_q;

endmodule

// File: tb/tb_wb_write_queue.sv
module tb_wb_write_queue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_register;
    logic [31:0] in_data;
    logic        wb_stall;
    logic        regwrite;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic [4:0]  lookup_register_1;
    logic [4:0]  lookup_register_2;
    logic        fwd_hit_1;
    logic        fwd_hit_2;
    logic [31:0] fwd_data_1;
    logic [31:0] fwd_data_2;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    wb_write_queue #(.DEPTH(4), .AW(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_register       (in_register),
        .in_data           (in_data),
        .wb_stall          (wb_stall),
        .regwrite          (regwrite),
        .write_register    (write_register),
        .write_data        (write_data),
        .lookup_register_1 (lookup_register_1),
        .lookup_register_2 (lookup_register_2),
        .fwd_hit_1         (fwd_hit_1),
        .fwd_hit_2         (fwd_hit_2),
        .fwd_data_1        (fwd_data_1),
        .fwd_data_2        (fwd_data_2),
        .count             (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        vld;
        logic [4:0]  rgs;
        logic [31:0] dat;
        logic        stall;
        logic [4:0]  lk1;
        logic [4:0]  lk2;
        logic        e_rdy;
        logic [2:0]  e_cnt;
        logic        e_rw;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic        e_h1;
        logic [31:0] e_d1;
        logic        e_h2;
        logic [31:0] e_d2;
    } vec_t;

    function automatic vec_t mk(input logic vld, input logic [4:0] rgs, input logic [31:0] dat,
                                input logic stall, input logic [4:0] lk1, input logic [4:0] lk2,
                                input logic e_rdy, input logic [2:0] e_cnt, input logic e_rw,
                                input logic [4:0] e_wr, input logic [31:0] e_wd,
                                input logic e_h1, input logic [31:0] e_d1,
                                input logic e_h2, input logic [31:0] e_d2);
        vec_t v;
        v.vld = vld; v.rgs = rgs; v.dat = dat; v.stall = stall; v.lk1 = lk1; v.lk2 = lk2;
        v.e_rdy = e_rdy; v.e_cnt = e_cnt; v.e_rw = e_rw; v.e_wr = e_wr; v.e_wd = e_wd;
        v.e_h1 = e_h1; v.e_d1 = e_d1; v.e_h2 = e_h2; v.e_d2 = e_d2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    logic [4:0]  cap_reg[$];
    logic [31:0] cap_dat[$];

    // Called at a negedge: records any register-file write seen this cycle.
    task automatic capture();
        if (regwrite) begin
            cap_reg.push_back(write_register);
            cap_dat.push_back(write_data);
        end
    endtask

    task automatic drive(input logic vld, input logic [4:0] rgs, input logic [31:0] dat,
                         input logic stall);
        in_valid    = vld;
        in_register = rgs;
        in_data     = dat;
        wb_stall    = stall;
    endtask

    vec_t vecs[16];

    initial begin
        // Table: outputs observed in a cycle, before the edge that consumes the inputs.
        //            vld rgs dat           stl lk1 lk2 rdy cnt rw wr  wd           h1 d1         h2 d2
        vecs[0]  = mk(0,  0,  32'h0,        0,  0,  0,  1,  0,  0, 0,  32'h0,       0, 32'h0,     0, 32'h0);
        vecs[1]  = mk(1,  8,  32'hAA,       0,  8,  0,  1,  0,  0, 0,  32'h0,       0, 32'h0,     0, 32'h0);
        vecs[2]  = mk(0,  0,  32'h0,        0,  8,  0,  1,  1,  0, 0,  32'h0,       1, 32'hAA,    0, 32'h0);
        vecs[3]  = mk(0,  0,  32'h0,        0,  8,  0,  1,  0,  1, 8,  32'hAA,      1, 32'hAA,    0, 32'h0);
        vecs[4]  = mk(0,  0,  32'h0,        0,  8,  0,  1,  0,  0, 8,  32'hAA,      0, 32'h0,     0, 32'h0);
        vecs[5]  = mk(1,  0,  32'hFFFFFFFF, 0,  0,  0,  1,  0,  0, 8,  32'hAA,      0, 32'h0,     0, 32'h0);
        vecs[6]  = mk(0,  0,  32'h0,        0,  0,  0,  1,  0,  0, 8,  32'hAA,      0, 32'h0,     0, 32'h0);
        vecs[7]  = mk(0,  0,  32'h0,        0,  8,  0,  1,  0,  0, 8,  32'hAA,      0, 32'h0,     0, 32'h0);
        vecs[8]  = mk(1,  3,  32'h100,      1,  3,  0,  1,  0,  0, 8,  32'hAA,      0, 32'h0,     0, 32'h0);
        vecs[9]  = mk(1,  3,  32'h200,      1,  3,  0,  1,  1,  0, 8,  32'hAA,      1, 32'h100,   0, 32'h0);
        vecs[10] = mk(0,  0,  32'h0,        1,  3,  0,  1,  2,  0, 8,  32'hAA,      1, 32'h200,   0, 32'h0);
        vecs[11] = mk(0,  0,  32'h0,        1,  7,  3,  1,  2,  0, 8,  32'hAA,      0, 32'h0,     1, 32'h200);
        vecs[12] = mk(0,  0,  32'h0,        0,  3,  3,  1,  2,  0, 8,  32'hAA,      1, 32'h200,   1, 32'h200);
        vecs[13] = mk(0,  0,  32'h0,        0,  3,  0,  1,  1,  1, 3,  32'h100,     1, 32'h200,   0, 32'h0);
        vecs[14] = mk(0,  0,  32'h0,        0,  3,  8,  1,  0,  1, 3,  32'h200,     1, 32'h200,   0, 32'h0);
        vecs[15] = mk(0,  0,  32'h0,        0,  3,  0,  1,  0,  0, 3,  32'h200,     0, 32'h0,     0, 32'h0);

        reset = 1'b1;
        drive(0, 0, 0, 0);
        lookup_register_1 = 0;
        lookup_register_2 = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int v = 0; v < 16; v++) begin
            drive(vecs[v].vld, vecs[v].rgs, vecs[v].dat, vecs[v].stall);
            lookup_register_1 = vecs[v].lk1;
            lookup_register_2 = vecs[v].lk2;
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", v), 32'(in_ready),       32'(vecs[v].e_rdy));
            chk($sformatf("v%0d_count", v),    32'(count),          32'(vecs[v].e_cnt));
            chk($sformatf("v%0d_regwrite", v), 32'(regwrite),       32'(vecs[v].e_rw));
            chk($sformatf("v%0d_wreg", v),     32'(write_register), 32'(vecs[v].e_wr));
            chk($sformatf("v%0d_wdata", v),    write_data,          vecs[v].e_wd);
            chk($sformatf("v%0d_hit1", v),     32'(fwd_hit_1),      32'(vecs[v].e_h1));
            chk($sformatf("v%0d_data1", v),    fwd_data_1,          vecs[v].e_d1);
            chk($sformatf("v%0d_hit2", v),     32'(fwd_hit_2),      32'(vecs[v].e_h2));
            chk($sformatf("v%0d_data2", v),    fwd_data_2,          vecs[v].e_d2);
            @(posedge clk);
            #1;
        end
        lookup_register_1 = 0;
        lookup_register_2 = 0;

        // ---------------- full queue under stall ----------------
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'(i + 1), 32'h11 * (i + 1), 1);
            @(negedge clk);
            chk($sformatf("full_count_%0d", i),    32'(count),    i);
            chk($sformatf("full_in_ready_%0d", i), 32'(in_ready), (i < 4) ? 1 : 0);
            chk($sformatf("full_regwrite_%0d", i), 32'(regwrite), 0);
            @(posedge clk);
            #1;
        end
        // Pop on the same edge as a push attempt into a full queue: push must be dropped.
        drive(1, 5'd6, 32'h66, 0);
        @(negedge clk);
        chk("full_bypass_in_ready", 32'(in_ready), 0);
        chk("full_bypass_count", 32'(count), 4);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("full_after_pop_count", 32'(count), 3);
        cap_reg.delete();
        cap_dat.delete();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            capture();
            @(posedge clk);
            #1;
        end
        chk("full_nwrites", cap_reg.size(), 4);
        for (int j = 0; j < 4; j++) begin
            if (j < cap_reg.size()) begin
                chk($sformatf("full_wr_reg_%0d", j), 32'(cap_reg[j]), j + 1);
                chk($sformatf("full_wr_dat_%0d", j), cap_dat[j], 32'h11 * (j + 1));
            end
        end

        // ---------------- continuous push/pop with pointer wrap ----------------
        cap_reg.delete();
        cap_dat.delete();
        for (int i = 0; i < 10; i++) begin
            drive(1, 5'(10 + i), 32'hC0DE0000 + i, 0);
            @(negedge clk);
            chk($sformatf("wrap_count_le1_%0d", i), 32'(count <= 3'd1), 1);
            chk($sformatf("wrap_in_ready_%0d", i), 32'(in_ready), 1);
            capture();
            @(posedge clk);
            #1;
        end
        drive(0, 0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            capture();
            @(posedge clk);
            #1;
        end
        chk("wrap_nwrites", cap_reg.size(), 10);
        for (int j = 0; j < 10; j++) begin
            if (j < cap_reg.size()) begin
                chk($sformatf("wrap_wr_reg_%0d", j), 32'(cap_reg[j]), 10 + j);
                chk($sformatf("wrap_wr_dat_%0d", j), cap_dat[j], 32'hC0DE0000 + j);
            end
        end
        chk("wrap_final_count", 32'(count), 0);

        // ---------------- reset with queued entries ----------------
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(5 + i), 32'h500 + i, 1);
            @(posedge clk);
            #1;
        end
        drive(0, 0, 0, 1);
        lookup_register_1 = 5;
        @(negedge clk);
        chk("pre_reset_count", 32'(count), 3);
        chk("pre_reset_hit1", 32'(fwd_hit_1), 1);
        chk("pre_reset_data1", fwd_data_1, 32'h500);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_count", 32'(count), 0);
        chk("post_reset_in_ready", 32'(in_ready), 1);
        chk("post_reset_regwrite", 32'(regwrite), 0);
        chk("post_reset_wreg", 32'(write_register), 0);
        chk("post_reset_wdata", write_data, 0);
        chk("post_reset_hit1", 32'(fwd_hit_1), 0);
        chk("post_reset_data1", fwd_data_1, 0);
        drive(0, 0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("post_reset_no_write_%0d", c), 32'(regwrite), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
